// File: rtl/cordic_div_pkg.sv
// Shared widths, normalisation targets and FSM encoding for the CORDIC divider front end.
package cordic_div_pkg;

  localparam int unsigned DW = 30;
  localparam int unsigned XW = 32;
  localparam int unsigned ZW = 17;
  localparam int unsigned EW = 7;
  localparam int unsigned CW = 5;

  localparam logic [ZW-1:0] Z_ONE = 17'h08000;

  localparam int unsigned X_NORM_BIT = 29;
  localparam int unsigned Y_NORM_BIT = 28;

  typedef enum logic [0:0] {
    StIdle,
    StNorm
  } state_e;

endpackage

// File: rtl/cordic_norm_shift.sv
// Magnitude register that shifts left until its target bit is set, counting the shifts taken.
module cordic_norm_shift
  import cordic_div_pkg::*;
#(
  parameter int unsigned W         = DW,
  parameter int unsigned TargetBit = X_NORM_BIT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [W-1:0]  load_val_i,
  input  logic          shift_en_i,
  output logic [W-1:0]  val_o,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  logic [W-1:0]  val_d, val_q;
  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (load_i) begin
      val_d = load_val_i;
      cnt_d = '0;
    end else if (shift_en_i && !val_q[TargetBit]) begin
      val_d = {val_q[W-2:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o  = val_q;
  assign cnt_o  = cnt_q;
  assign done_o = val_q[TargetBit];

endmodule

// File: rtl/cordic_divide_prenorm.sv
// Divider front end: strips operand signs and normalises both magnitudes for the divide stages,
// producing the sign/exponent/divide-by-zero sideband for the post-scaler.
module cordic_divide_prenorm
  import cordic_div_pkg::*;
(
  input  logic          rx_clk,
  input  logic          rx_rst_n,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [DW-1:0] rx_num,
  input  logic [DW-1:0] rx_den,
  output logic          tx_valid,
  output logic [XW-1:0] tx_x,
  output logic [XW-1:0] tx_y,
  output logic [ZW-1:0] tx_z,
  output logic          tx_neg,
  output logic [EW-1:0] tx_exp,
  output logic          tx_dz
);

  state_e        state_d, state_q;
  logic          rx_ready_d, rx_ready_q;
  logic          sign_d, sign_q;
  logic          dz_d, dz_q;
  logic          nz_d, nz_q;
  logic          half_d, half_q;
  logic          tx_valid_d, tx_valid_q;
  logic [XW-1:0] tx_x_d, tx_x_q;
  logic [XW-1:0] tx_y_d, tx_y_q;
  logic          tx_neg_d, tx_neg_q;
  logic [EW-1:0] tx_exp_d, tx_exp_q;
  logic          tx_dz_d, tx_dz_q;

  logic [DW-1:0] abs_num, abs_den, y_load;
  logic [DW-1:0] x_val, y_val;
  logic [CW-1:0] x_cnt, y_cnt;
  logic          x_done, y_done;
  logic          accept, fin, shift_en;
  logic [EW-1:0] exp_norm;

  always_comb begin
    abs_num  = rx_num[DW-1] ? -rx_num : rx_num;
    abs_den  = rx_den[DW-1] ? -rx_den : rx_den;
    // Only N = -2^(DW-1) reaches the top bit; pre-halve it and credit one right shift.
    y_load   = abs_num[DW-1] ? (abs_num >> 1) : abs_num;
    accept   = (state_q == StIdle) && rx_ready_q && rx_valid;
    fin      = (state_q == StNorm) && (dz_q || nz_q || (x_done && y_done));
    shift_en = (state_q == StNorm) && !fin;
    exp_norm = EW'(x_cnt) - EW'(y_cnt) + EW'(half_q);
  end

  cordic_norm_shift #(
    .W         (DW),
    .TargetBit (X_NORM_BIT)
  ) u_norm_x (
    .clk_i      (rx_clk),
    .rst_ni     (rx_rst_n),
    .load_i     (accept),
    .load_val_i (abs_den),
    .shift_en_i (shift_en),
    .val_o      (x_val),
    .cnt_o      (x_cnt),
    .done_o     (x_done)
  );

  cordic_norm_shift #(
    .W         (DW),
    .TargetBit (Y_NORM_BIT)
  ) u_norm_y (
    .clk_i      (rx_clk),
    .rst_ni     (rx_rst_n),
    .load_i     (accept),
    .load_val_i (y_load),
    .shift_en_i (shift_en),
    .val_o      (y_val),
    .cnt_o      (y_cnt),
    .done_o     (y_done)
  );

  always_comb begin
    state_d    = state_q;
    rx_ready_d = rx_ready_q;
    sign_d     = sign_q;
    dz_d       = dz_q;
    nz_d       = nz_q;
    half_d     = half_q;
    tx_valid_d = 1'b0;
    tx_x_d     = tx_x_q;
    tx_y_d     = tx_y_q;
    tx_neg_d   = tx_neg_q;
    tx_exp_d   = tx_exp_q;
    tx_dz_d    = tx_dz_q;

    unique case (state_q)
      StIdle: begin
        rx_ready_d = 1'b1;
        if (accept) begin
          state_d    = StNorm;
          rx_ready_d = 1'b0;
          sign_d     = rx_num[DW-1] ^ rx_den[DW-1];
          dz_d       = (rx_den == '0);
          nz_d       = (rx_num == '0);
          half_d     = abs_num[DW-1];
        end
      end
      StNorm: begin
        if (fin) begin
          state_d    = StIdle;
          rx_ready_d = 1'b1;
          tx_valid_d = 1'b1;
          if (dz_q) begin
            tx_x_d   = '0;
            tx_y_d   = '0;
            tx_exp_d = '0;
            tx_neg_d = 1'b0;
            tx_dz_d  = 1'b1;
          end else if (nz_q) begin
            tx_x_d             = '0;
            tx_x_d[X_NORM_BIT] = 1'b1;
            tx_y_d             = '0;
            tx_exp_d           = '0;
            tx_neg_d           = 1'b0;
            tx_dz_d            = 1'b0;
          end else begin
            tx_x_d   = XW'(x_val);
            tx_y_d   = XW'(y_val);
            tx_exp_d = exp_norm;
            tx_neg_d = sign_q;
            tx_dz_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      state_q    <= StIdle;
      rx_ready_q <= 1'b0;
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      nz_q       <= 1'b0;
      half_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_x_q     <= '0;
      tx_y_q     <= '0;
      tx_neg_q   <= 1'b0;
      tx_exp_q   <= '0;
      tx_dz_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      sign_q     <= sign_d;
      dz_q       <= dz_d;
      nz_q       <= nz_d;
      half_q     <= half_d;
      tx_valid_q <= tx_valid_d;
      tx_x_q     <= tx_x_d;
      tx_y_q     <= tx_y_d;
      tx_neg_q   <= tx_neg_d;
      tx_exp_q   <= tx_exp_d;
      tx_dz_q    <= tx_dz_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_x     = tx_x_q;
  assign tx_y     = tx_y_q;
  assign tx_z     = '0;
  assign tx_neg   = tx_neg_q;
  assign tx_exp   = tx_exp_q;
  assign tx_dz    = tx_dz_q;

endmodule

// File: tb/tb_cordic_divide_prenorm.sv
// Bench for cordic_divide_prenorm: arithmetic reference model, per-edge output compare.
module tb_cordic_divide_prenorm;

  localparam int Big = 1000000;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [29:0] rx_num = '0;
  logic [29:0] rx_den = '0;
  logic        tx_valid;
  logic [31:0] tx_x;
  logic [31:0] tx_y;
  logic [16:0] tx_z;
  logic        tx_neg;
  logic [6:0]  tx_exp;
  logic        tx_dz;

  cordic_divide_prenorm dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_num   (rx_num),
    .rx_den   (rx_den),
    .tx_valid (tx_valid),
    .tx_x     (tx_x),
    .tx_y     (tx_y),
    .tx_z     (tx_z),
    .tx_neg   (tx_neg),
    .tx_exp   (tx_exp),
    .tx_dz    (tx_dz)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    int          due;
    logic [31:0] x;
    logic [31:0] y;
    logic [6:0]  e;
    logic        neg;
    logic        dz;
  } rec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   ready_edge = Big;
  rec_t exp_q[$];
  rec_t hold = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, req, edge_n);
    end
  endfunction

  // Quotient setup from first principles: shift counts from the operand's leading-one position.
  function automatic rec_t model(input int n, input int d, output int k);
    rec_t r;
    int an, ad, sd, sn;
    r  = '0;
    k  = 0;
    an = (n < 0) ? -n : n;
    ad = (d < 0) ? -d : d;
    if (d == 0) begin
      r.dz = 1'b1;
    end else if (n == 0) begin
      r.x = 32'h2000_0000;
    end else begin
      sd  = 29 - ($clog2(ad + 1) - 1);
      r.x = 32'(ad << sd);
      if (an == (1 << 29)) begin
        sn  = -1;
        r.y = 32'h1000_0000;
      end else begin
        sn  = 28 - ($clog2(an + 1) - 1);
        r.y = 32'(an << sn);
      end
      r.e   = 7'(sd - sn);
      r.neg = (n < 0) != (d < 0);
      k     = (sd > sn) ? sd : sn;
    end
    return r;
  endfunction

  task automatic send(input int n, input int d, input logic [31:0] lx, input logic [31:0] ly,
                      input logic [6:0] le, input logic lneg, input logic ldz, input int llat);
    rec_t r;
    int   k, e0;
    r = model(n, d, k);
    chk("model_x", r.x, lx);
    chk("model_y", r.y, ly);
    chk("model_exp", 32'(r.e), 32'(le));
    chk("model_neg", 32'(r.neg), 32'(lneg));
    chk("model_dz", 32'(r.dz), 32'(ldz));
    chk("model_latency", 32'(k + 1), 32'(llat));
    @(negedge rx_clk);
    rx_valid = 1'b1;
    rx_num   = 30'(n);
    rx_den   = 30'(d);
    e0 = (edge_n + 1 > ready_edge + 1) ? edge_n + 1 : ready_edge + 1;
    wait (edge_n >= e0);
    r.due      = e0 + k + 1;
    ready_edge = r.due;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge rx_clk);
    rx_valid = 1'b0;
    while ((exp_q.size() != 0 || edge_n < ready_edge) && t < 100) begin
      @(negedge rx_clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge rx_clk);
    rx_rst_n   = 1'b0;
    rx_valid   = 1'b0;
    ready_edge = Big;
    repeat (cycles) @(negedge rx_clk);
    rx_rst_n   = 1'b1;
    ready_edge = edge_n + 1;
  endtask

  always @(posedge rx_clk) begin : monitor
    logic rst_s, exp_v, exp_rdy;
    edge_n++;
    rst_s = rx_rst_n;
    #1;
    exp_v   = 1'b0;
    exp_rdy = 1'b0;
    if (!rst_s) begin
      hold = '0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
        hold  = exp_q.pop_front();
        exp_v = 1'b1;
      end
      exp_rdy = (edge_n >= ready_edge);
    end
    chk("rx_ready", 32'(rx_ready), 32'(exp_rdy));
    chk("tx_valid", 32'(tx_valid), 32'(exp_v));
    chk("tx_x", tx_x, hold.x);
    chk("tx_y", tx_y, hold.y);
    chk("tx_z", 32'(tx_z), 32'h0);
    chk("tx_exp", 32'(tx_exp), 32'(hold.e));
    chk("tx_neg", 32'(tx_neg), 32'(hold.neg));
    chk("tx_dz", 32'(tx_dz), 32'(hold.dz));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);

    send(6, 3, 32'h3000_0000, 32'h1800_0000, 7'd2, 1'b0, 1'b0, 29);
    drain();
    send(-5, 1, 32'h2000_0000, 32'h1400_0000, 7'd3, 1'b1, 1'b0, 30);
    drain();
    send(-(1 << 29), -1, 32'h2000_0000, 32'h1000_0000, 7'd30, 1'b0, 1'b0, 30);
    drain();
    send(7, 0, 32'h0, 32'h0, 7'd0, 1'b0, 1'b1, 1);
    drain();
    send(0, -9, 32'h2000_0000, 32'h0, 7'd0, 1'b0, 1'b0, 1);
    drain();
    send(0, 0, 32'h0, 32'h0, 7'd0, 1'b0, 1'b1, 1);
    drain();
    send((1 << 29) - 1, -(1 << 29), 32'h2000_0000, 32'h1FFF_FFFF, 7'd0, 1'b1, 1'b0, 1);
    drain();
    send(1, (1 << 29) - 1, 32'h3FFF_FFFE, 32'h1000_0000, 7'h65, 1'b0, 1'b0, 29);
    drain();

    // Back-to-back with rx_valid held high across both pairs.
    send(6, 3, 32'h3000_0000, 32'h1800_0000, 7'd2, 1'b0, 1'b0, 29);
    send(-5, 1, 32'h2000_0000, 32'h1400_0000, 7'd3, 1'b1, 1'b0, 30);
    drain();

    // Reset in the middle of a long normalisation must swallow the result.
    send(1, 1, 32'h2000_0000, 32'h1000_0000, 7'd1, 1'b0, 1'b0, 30);
    repeat (5) @(negedge rx_clk);
    do_reset(1);
    drain();

    send(3, -6, 32'h3000_0000, 32'h1800_0000, 7'd0, 1'b1, 1'b0, 28);
    drain();
    repeat (3) @(negedge rx_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_divide_prenorm.md
Name: cordic_divide_prenorm

Overview:
- Front end of the linear-mode CORDIC divider pipeline.
- Accepts a signed dividend/divisor pair and strips the signs.
- Normalises both magnitudes by iterative left shifts so every downstream divide stage sees x in [2^29, 2^30), y in [2^28, 2^29) and a ratio in (0.25, 1).
- Emits x, y, z = 0 as the first-stage inputs, plus the sign, exponent and divide-by-zero sideband consumed by the post-scaler.

Parameters:
- DW, 30: signed input width; |value| <= 2^(DW-1).
- XW, 32: x/y output width, matching the divide stages.
- ZW, 17: z output width (Q2.15, 1.0 = 17'h08000).
- EW, 7: signed exponent width.

Ports:
- rx_clk  in  1  clock
- rx_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- rx_valid  in  1  operand pair valid
- rx_ready  out  1  block can accept (high only in IDLE)
- rx_num  in  DW  signed dividend N
- rx_den  in  DW  signed divisor D
- tx_valid  out  1  one-cycle pulse, outputs valid
- tx_x  out  XW  normalised |D|, positive
- tx_y  out  XW  normalised |N|, positive
- tx_z  out  ZW  always 0
- tx_neg  out  1  sign(N) xor sign(D); 0 if N==0 or D==0
- tx_exp  out  EW  signed shift exponent e; true |q| = z * 2^e
- tx_dz  out  1  divisor was zero

Behaviour:
- Reset (rx_rst_n low at an edge): state IDLE, all tx_* = 0, rx_ready = 0, internal regs = 0. rx_ready rises at the first edge with rx_rst_n high. Reset mid-NORM discards the operation; no tx_valid is produced.
- FSM states: IDLE, NORM. No backpressure downstream: tx_valid is a single-cycle pulse.
- IDLE:
  - rx_ready = 1.
  - On rx_valid at edge E0:
    - latch ax = |D|, ay = |N| (DW bits), sign = N[DW-1] xor D[DW-1].
    - sD = 0.
    - If ay[29] is set (only N = -2^29): ay = ay >> 1, sN = -1; otherwise sN = 0.
    - Flags dz = (D==0), nz = (N==0).
    - Go to NORM; rx_ready = 0.
  - While rx_valid is low, stay in IDLE.
- NORM, each cycle:
  - If dz, nz, or (ax[29] and ay[28]): register outputs at the next edge, set tx_valid = 1, rx_ready = 1, state = IDLE.
  - Otherwise, in parallel:
    - if !ax[29]: ax <<= 1, sD++.
    - if !ay[28]: ay <<= 1, sN++.
- Latency: tx_valid at edge E0 + k + 1, where k = max(sD, sN) counting only left shifts. Worst case k = 29, i.e. 30 edges.
- Throughput: the next operand may be accepted in the same cycle tx_valid is high.
- Outputs at completion:
  - Normal: tx_x = zero-extended ax, tx_y = zero-extended ay, tx_z = 0, tx_exp = sD - sN (range -28..30), tx_neg = sign, tx_dz = 0.
  - dz: tx_x = 0, tx_y = 0, tx_exp = 0, tx_neg = 0, tx_dz = 1; completes with k = 0.
  - nz (D != 0): tx_x = 2^29, tx_y = 0, tx_exp = 0, tx_neg = 0, tx_dz = 0; completes with k = 0.
  - Both zero: dz takes precedence.
- Between tx_valid pulses, tx_* hold their last values.
- Width rules: x < 2^30 and |y| < x, so the y ± x sums in the downstream stages fit in signed XW. Shift counters are 5 bits; the exponent subtraction is done in EW bits signed.

Decomposition:
- Shared package cordic_div_pkg holds:
  - constants Z_ONE = 17'h08000, X_NORM_BIT = 29, Y_NORM_BIT = 28, widths DW/XW/ZW/EW;
  - the FSM state encoding.
- One sub-module, cordic_norm_shift, instantiated twice (x and y):
  - register, shift-until-target-bit-set, shift counter;
  - outputs a done flag.

Test Plan:
- N=6, D=3 -> sD=28, sN=26; tx_x=0x3000_0000, tx_y=0x1800_0000, tx_exp=2, tx_neg=0; tx_valid 29 edges after accept.
- N=-5, D=1 -> tx_x=0x2000_0000, tx_y=0x1400_0000, tx_exp=3, tx_neg=1; tx_valid 30 edges after accept.
- N=-2^29, D=-1 -> sN=-1, tx_y=0x1000_0000, tx_x=0x2000_0000, tx_exp=30, tx_neg=0.
- D=0 with N=7 -> tx_dz=1, x=y=0, tx_valid 1 edge after accept. Separately, N=0 with D=-9 -> tx_x=0x2000_0000, tx_y=0, tx_neg=0, tx_dz=0.
- Back-to-back: rx_valid held high with two pairs -> second pair accepted in the tx_valid cycle of the first; rx_ready low throughout NORM.
- rx_rst_n pulled low for 1 cycle mid-NORM -> no tx_valid; all outputs 0; rx_ready high the edge after release.
